button_event_queue: RTL

- Captures debounced button presses from the four game buttons (red, blue, green, yellow) and queues them as color events.
- The processor reads events through the memory-mapped read port at data address 7; each read pops one event.
- Sits between the raw button pins and the address-7 read mux that drives memDataOut.
- Quick presses made between processor polls are not lost, and each press is reported exactly once.

---
 rtl/button_event_queue_if.sv | 23 ++
 rtl/button_event_queue.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/button_event_queue_if.sv
// Processor-facing signal bundle for the button event queue: raw button pins,
// address-7 poll strobe, read data and queue occupancy.
interface button_event_queue_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                             red_button;
    logic                             blue_button;
    logic                             green_button;
    logic                             yellow_button;
    logic                             poll;
    logic [31:0]                      button_out;
    logic [$clog2(FIFO_DEPTH+1)-1:0]  count;

    modport master (
        output red_button, blue_button, green_button, yellow_button, poll,
        input  button_out, count
    );

    modport slave (
        input  red_button, blue_button, green_button, yellow_button, poll,
        output button_out, count
    );
endinterface

// File: rtl/button_event_queue.sv
// Debounces the four game buttons, turns presses into 2-bit color events and
// queues them for the processor, which pops one event per address-7 access.
module button_event_queue #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_W           = 19
) (
    input logic                 clock,
    input logic                 reset,
    button_event_queue_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    // Button vectors are indexed red=0, blue=1, green=2, yellow=3 (= color code)
    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       stable;
    logic [3:0]       flip;
    logic [3:0]       rise;
    logic [CNT_W-1:0] db_cnt [4];

    logic             ev_valid;
    logic             ev_multi;
    logic [1:0]       ev_color;

    logic [1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             overflow;
    logic             poll_d;
    logic [31:0]      hold;

    logic             empty;
    logic             full;
    logic             pop_edge;
    logic             do_pop;
    logic             do_push;
    logic             ovf_set;
    logic [31:0]      head_view;

    always_comb begin
        raw = {bus.yellow_button, bus.green_button, bus.blue_button, bus.red_button};
    end

    always_comb begin
        flip = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            flip[i] = (sync2[i] != stable[i]) && (db_cnt[i] == CNT_LAST);
        end
        rise = flip & sync2;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (flip[i]) begin
                    db_cnt[i] <= '0;
                    stable[i] <= ~stable[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Lowest index wins; any extra simultaneous press counts as an overflow
    always_comb begin
        ev_valid = |rise;
        ev_multi = |(rise & (rise - 4'd1));
        if (rise[0])      ev_color = 2'd0;
        else if (rise[1]) ev_color = 2'd1;
        else if (rise[2]) ev_color = 2'd2;
        else if (rise[3]) ev_color = 2'd3;
        else              ev_color = 2'd0;
    end

    always_comb begin
        empty     = (occ == '0);
        full      = (occ == OCC_FULL);
        pop_edge  = bus.poll && !poll_d;
        do_pop    = pop_edge && !empty;
        // A same-edge pop frees the slot, so a full queue still accepts the push
        do_push   = ev_valid && (!full || do_pop);
        ovf_set   = ev_multi || (ev_valid && !do_push);
        head_view = empty ? {overflow, 31'b0}
                          : {overflow, 28'b0, 1'b1, mem[rd_ptr]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
            poll_d   <= 1'b0;
            hold     <= '0;
        end else begin
            poll_d <= bus.poll;
            if (do_push) begin
                mem[wr_ptr] <= ev_color;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (pop_edge) begin
                hold <= head_view;
            end
            // Clear only once the flag has actually been reported to the reader
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (pop_edge && overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.button_out = (bus.poll && poll_d) ? hold : head_view;
        bus.count      = occ;
    end
endmodule
